// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the N-channel stream multiplexer: mode codes, FSM
// state encoding and the select-width helper.
package stream_mux_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Channel-index width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational rotating-priority arbiter: the highest priority request is the
// one just after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready multiplexer with packet-granular grants (fixed or
// round-robin) onto a single registered output stream.
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 16,
  localparam int SEL_W  = sel_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready,
  output logic                   busy
);

  state_t             state, state_nx;
  logic [SEL_W-1:0]   g, g_nx;
  logic [SEL_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [SEL_W-1:0]   rr_gnt;
  logic               rr_any;
  logic [SEL_W-1:0]   sel_idx;
  logic               sel_ok;
  logic               space, accept;
  logic [DATA_W-1:0]  g_data;

  rr_arbiter #(.N(N_CH), .IW(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_gnt),
    .any     (rr_any)
  );

  // Out-of-range select is simply no request; a single channel ignores sel.
  always_comb begin
    if (N_CH == 1) begin
      sel_ok  = 1'b1;
      sel_idx = '0;
    end else begin
      sel_ok  = int'(sel) < N_CH;
      sel_idx = sel_ok ? sel : '0;
    end
  end

  assign space  = !out_valid || out_ready;
  assign g_data = in_data[int'(g)*DATA_W +: DATA_W];
  assign accept = (state == ST_LOCKED) && in_valid[g] && space;
  assign busy   = (state == ST_LOCKED);

  always_comb begin
    for (int i = 0; i < N_CH; i++)
      in_ready[i] = (state == ST_LOCKED) && space && (int'(g) == i);
  end

  always_comb begin
    state_nx  = state;
    g_nx      = g;
    rr_ptr_nx = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_RR) begin
          if (rr_any) begin
            g_nx     = rr_gnt;
            state_nx = ST_LOCKED;
          end
        end else if (sel_ok && in_valid[sel_idx]) begin
          g_nx     = sel_idx;
          state_nx = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept && in_last[g]) begin
          state_nx  = ST_IDLE;
          rr_ptr_nx = g;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      g         <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state  <= state_nx;
      g      <= g_nx;
      rr_ptr <= rr_ptr_nx;
      if (accept) begin
        out_data  <= g_data;
        out_last  <= in_last[g];
        out_ch    <= g;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
